mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port RAM (CS/WE/ADDR/DataIn -> out/ready) between two requesters:
//  port F (instruction fetch) and port D (load/store data). Round-robin grant, one access
//  in flight, drives RAM strobes, captures read data, returns per-port ACK pulses.
//  Timeout on a missing RAM ready. Sits between the LC-3 control FSM and RAM.
// PARAMETERS
//  TIMEOUT  8   max WAIT cycles for MEM_READY before error completion (>=1)
// PORTS
//  CLK        in   1   clock, all state updates on posedge
//  RST        in   1   reset, asynchronous, active-high
//  F_REQ      in   1   fetch request; held with F_ADDR until F_ACK
//  F_ADDR     in   16  fetch address (fetch is always a read)
//  F_ACK      out  1   one-cycle completion pulse for port F
//  D_REQ      in   1   data request; held with D_WE/D_ADDR/D_WDATA until D_ACK
//  D_WE       in   1   1 = store, 0 = load
//  D_ADDR     in   16  data address
//  D_WDATA    in   16  store data
//  D_ACK      out  1   one-cycle completion pulse for port D
//  RDATA      out  16  read data, valid in the ACK cycle, held until next read completes
//  ERR        out  1   high with ACK when the access timed out (RDATA unchanged)
//  BUSY       out  1   high in any state other than IDLE
//  MEM_CS     out  1   RAM chip select, high for exactly one cycle per access
//  MEM_WE     out  1   RAM write enable, qualified by MEM_CS
//  MEM_ADDR   out  16  RAM address, driven from latched request
//  MEM_DATA   out  16  RAM write data, driven from latched request
//  MEM_OUT    in   16  RAM read data
//  MEM_READY  in   1   RAM read-complete flag (may be stale while MEM_CS low)
// BEHAVIOUR
//  Reset: state IDLE; F_ACK, D_ACK, ERR, BUSY, MEM_CS, MEM_WE = 0; RDATA, MEM_ADDR,
//   MEM_DATA = 0; last-grant = D (so F wins the first contention); timeout count = 0.
//  States: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
//  IDLE: if any REQ, pick winner, latch port id, WE, ADDR, WDATA; go ISSUE.
//   Only one REQ high: that port wins. Both high: the port not granted last wins.
//   Last-grant updates on every grant.
//  ISSUE: MEM_CS=1, MEM_WE=latched WE (0 for F). Read -> WAIT, count=0. Write -> RESP.
//  WAIT: MEM_CS=0. MEM_READY=1 -> capture MEM_OUT into RDATA, go RESP, ERR=0.
//   Else count+1; when count reaches TIMEOUT-1 with no ready -> RESP with ERR=1.
//   MEM_READY is sampled only in WAIT (stale ready outside WAIT is ignored).
//  RESP: ACK of granted port = 1 for this cycle only; ERR valid same cycle; -> IDLE.
//  Latency REQ-sampled to ACK: read 3 cycles (IDLE, ISSUE, WAIT, ACK in 4th),
//   write 2 cycles (IDLE, ISSUE, ACK in 3rd). Back-to-back: IDLE re-entered, next
//   grant earliest the cycle after RESP (no grant in RESP).
//  Requester dropping REQ while granted: access still completes, ACK still pulses.
//  REQ sampled only in IDLE; ADDR/WDATA changes after grant have no effect.
//  Never both ACKs in one cycle; never MEM_CS high outside ISSUE.
//  RST mid-access: immediate return to reset values; no ACK for the aborted access.
//  Address/data are 16-bit, no arithmetic; count width clog2(TIMEOUT)+1.
// TESTING
//  F_REQ, F_ADDR=0x0000, RAM word0=0x5260 -> MEM_CS one cycle, F_ACK in 4th cycle, RDATA=0x5260.
//  D_REQ, D_WE=1, D_ADDR=0x3000, D_WDATA=0xBEEF, then D load 0x3000 -> RDATA=0xBEEF.
//  F_REQ and D_REQ held together from reset -> grants F, D, F, D alternating; no dual ACK.
//  Memory model holds MEM_READY=0, TIMEOUT=8 -> F_ACK with ERR=1 after 8 WAIT cycles.
//  Stale MEM_READY=1 while idle then D write -> write ACK in 3rd cycle, RDATA unchanged.
//  RST pulsed in WAIT -> outputs at reset values async, no ACK; next request served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between an instruction-fetch port (F)
// and a load/store data port (D). One access is in flight at a time. Grants
// are round-robin under contention. The arbiter drives the RAM strobes,
// captures the read data and returns a one-cycle ACK to the granted port. A
// read that never sees MEM_READY completes with ERR after TIMEOUT wait cycles.
//
// Ports
//   CLK, RST                    clock; asynchronous active-high reset
//   F_REQ/F_ADDR -> F_ACK       fetch port (always a read)
//   D_REQ/D_WE/D_ADDR/D_WDATA   data port (load or store)
//     -> D_ACK
//   RDATA, ERR                  read data (held until the next good read);
//                               ERR is a timeout flag that is valid with the ACK
//   BUSY                        high whenever the arbiter is not idle
//   MEM_CS/MEM_WE/MEM_ADDR/     RAM strobes, address and write data
//     MEM_DATA
//   MEM_OUT/MEM_READY           RAM read data and read-complete flag
module mem_arbiter #(
  parameter int TIMEOUT = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        F_REQ,
  input  logic [15:0] F_ADDR,
  output logic        F_ACK,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [15:0] D_ADDR,
  input  logic [15:0] D_WDATA,
  output logic        D_ACK,
  output logic [15:0] RDATA,
  output logic        ERR,
  output logic        BUSY,
  output logic        MEM_CS,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_DATA,
  input  logic [15:0] MEM_OUT,
  input  logic        MEM_READY
);

  localparam int            CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic          port_q,  port_d;   // granted port: 0 = F, 1 = D
  logic          last_q,  last_d;   // last granted port, same encoding
  logic          we_q,    we_d;
  logic          err_q,   err_d;
  logic [15:0]   addr_q,  addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      port_q  <= 1'b0;
      last_q  <= 1'b1;              // D counts as last, so F wins the first tie
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      last_q  <= last_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    last_d  = last_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (F_REQ || D_REQ) begin
          // A single requester wins outright; on a tie, the port not served last wins.
          port_d  = (F_REQ && D_REQ) ? ~last_q : D_REQ;
          last_d  = port_d;
          we_d    = port_d ? D_WE : 1'b0;
          addr_d  = port_d ? D_ADDR : F_ADDR;
          if (port_d) wdata_d = D_WDATA;
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = we_q ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        // Ready is checked before the timeout, so a ready seen on the last
        // allowed cycle still completes as a good read.
        if (MEM_READY) begin
          rdata_d = MEM_OUT;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The strobes and ACKs decode straight from the state, so an async reset
  // returns them to 0 at once.
  assign MEM_CS   = (state_q == S_ISSUE);
  assign MEM_WE   = MEM_CS & we_q;
  assign MEM_ADDR = addr_q;
  assign MEM_DATA = wdata_q;
  assign F_ACK    = (state_q == S_RESP) & ~port_q;
  assign D_ACK    = (state_q == S_RESP) &  port_q;
  assign ERR      = (state_q == S_RESP) &  err_q;
  assign BUSY     = (state_q != S_IDLE);
  assign RDATA    = rdata_q;

endmodule
